// File: rtl/operand_collector.sv
// operand_collector: gathers OperandsPerInst register-file reads per dispatched instruction, accept->eu_valid_o in 2*OperandsPerInst+1 cycles.
// Backpressure: accepts only when idle; stalls on rf_req_ready_i, rf_rsp_valid_i and eu_ready_i. Macro OPC_ZERO_REG_EN skips reads of r0.
module operand_collector #(
  parameter int PcWidth         = 16,
  parameter int NumWarps        = 8,
  parameter int WarpWidth       = 4,
  parameter int RegIdxWidth     = 8,
  parameter int OperandsPerInst = 2,
  parameter int RegWidth        = 32,
  localparam int WidWidth       = (NumWarps > 1) ? $clog2(NumWarps) : 1,
  localparam int IdxW           = (OperandsPerInst > 1) ? $clog2(OperandsPerInst) : 1
) (
  input  logic                                          clk_i,
  input  logic                                          rst_ni,
  input  logic                                          disp_valid_i,
  output logic                                          opc_ready_o,
  input  logic [PcWidth-1:0]                            disp_pc_i,
  input  logic [WarpWidth-1:0]                          disp_act_mask_i,
  input  logic [WidWidth-1:0]                           disp_warp_id_i,
  input  logic [RegIdxWidth-1:0]                        disp_dst_i,
  input  logic [OperandsPerInst*RegIdxWidth-1:0]        disp_src_i,
  output logic                                          rf_req_valid_o,
  input  logic                                          rf_req_ready_i,
  output logic [WidWidth-1:0]                           rf_req_warp_id_o,
  output logic [RegIdxWidth-1:0]                        rf_req_reg_idx_o,
  input  logic                                          rf_rsp_valid_i,
  input  logic [WarpWidth*RegWidth-1:0]                 rf_rsp_data_i,
  output logic                                          eu_valid_o,
  input  logic                                          eu_ready_i,
  output logic [PcWidth-1:0]                            eu_pc_o,
  output logic [WarpWidth-1:0]                          eu_act_mask_o,
  output logic [WidWidth-1:0]                           eu_warp_id_o,
  output logic [RegIdxWidth-1:0]                        eu_dst_o,
  output logic [OperandsPerInst*WarpWidth*RegWidth-1:0] eu_operands_o
);

  localparam int OpW = WarpWidth * RegWidth;

  typedef enum logic [1:0] {
    StIdle,
    StReq,
    StWait,
    StOut
  } state_e;

  typedef struct packed {
    logic [PcWidth-1:0]                         pc;
    logic [WarpWidth-1:0]                       mask;
    logic [WidWidth-1:0]                        wid;
    logic [RegIdxWidth-1:0]                     dst;
    logic [OperandsPerInst-1:0][RegIdxWidth-1:0] src;
  } inst_t;

  state_e                              state_q, state_d;
  logic [IdxW-1:0]                     idx_q, idx_d;
  inst_t                               inst_q, inst_d;
  logic [OperandsPerInst-1:0][OpW-1:0] opnd_q, opnd_d;

  logic [RegIdxWidth-1:0] cur_src;
  logic                   last_op;
  logic                   skip_zero;

  assign cur_src = inst_q.src[idx_q];
  assign last_op = (idx_q == IdxW'(OperandsPerInst - 1));

`ifdef OPC_ZERO_REG_EN
  // r0 reads as zero without touching the register file
  assign skip_zero = (cur_src == '0);
`else
  assign skip_zero = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    inst_d  = inst_q;
    opnd_d  = opnd_q;
    case (state_q)
      StIdle: begin
        if (disp_valid_i) begin
          inst_d.pc   = disp_pc_i;
          inst_d.mask = disp_act_mask_i;
          inst_d.wid  = disp_warp_id_i;
          inst_d.dst  = disp_dst_i;
          inst_d.src  = disp_src_i;
          idx_d       = '0;
          state_d     = StReq;
        end
      end
      StReq: begin
        if (skip_zero) begin
          opnd_d[idx_q] = '0;
          if (last_op) begin
            state_d = StOut;
          end else begin
            idx_d   = idx_q + IdxW'(1);
            state_d = StReq;
          end
        end else if (rf_req_ready_i) begin
          state_d = StWait;
        end
      end
      StWait: begin
        if (rf_rsp_valid_i) begin
          opnd_d[idx_q] = rf_rsp_data_i;
          if (last_op) begin
            state_d = StOut;
          end else begin
            idx_d   = idx_q + IdxW'(1);
            state_d = StReq;
          end
        end
      end
      StOut: begin
        if (eu_ready_i) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      idx_q   <= '0;
      inst_q  <= '0;
      opnd_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      inst_q  <= inst_d;
      opnd_q  <= opnd_d;
    end
  end

  // Handshake outputs are pure functions of registered state
  assign opc_ready_o      = (state_q == StIdle);
  assign rf_req_valid_o   = (state_q == StReq) && !skip_zero;
  assign rf_req_warp_id_o = inst_q.wid;
  assign rf_req_reg_idx_o = cur_src;

  assign eu_valid_o    = (state_q == StOut);
  assign eu_pc_o       = inst_q.pc;
  assign eu_act_mask_o = inst_q.mask;
  assign eu_warp_id_o  = inst_q.wid;
  assign eu_dst_o      = inst_q.dst;
  assign eu_operands_o = opnd_q;

`ifndef SYNTHESIS
  a_rsp_in_wait: assert property (@(posedge clk_i) disable iff (!rst_ni)
    rf_rsp_valid_i |-> (state_q == StWait))
    else $error("operand_collector: rf_rsp_valid_i outside WAIT is ignored");

  a_req_eu_excl: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(rf_req_valid_o && eu_valid_o))
    else $error("operand_collector: rf_req_valid_o and eu_valid_o both high");
`endif

endmodule

// File: tb/tb_operand_collector.sv
// Scoreboard bench for operand_collector: RF responder and EU sink with programmable stalls, queues of expected requests and outputs.
module tb_operand_collector;

  localparam int WW  = 4;
  localparam int OpW = WW * 32;
`ifdef OPC_ZERO_REG_EN
  localparam int ZeroLat  = 3;
  localparam int ZeroReqs = 0;
`else
  localparam int ZeroLat  = 5;
  localparam int ZeroReqs = 2;
`endif

  logic           clk_i = 1'b0;
  logic           rst_ni = 1'b0;
  logic           disp_valid_i = 1'b0;
  logic           opc_ready_o;
  logic [15:0]    disp_pc_i = '0;
  logic [3:0]     disp_act_mask_i = '0;
  logic [2:0]     disp_warp_id_i = '0;
  logic [7:0]     disp_dst_i = '0;
  logic [15:0]    disp_src_i = '0;
  logic           rf_req_valid_o;
  logic           rf_req_ready_i;
  logic [2:0]     rf_req_warp_id_o;
  logic [7:0]     rf_req_reg_idx_o;
  logic           rf_rsp_valid_i;
  logic [OpW-1:0] rf_rsp_data_i;
  logic           eu_valid_o;
  logic           eu_ready_i;
  logic [15:0]    eu_pc_o;
  logic [3:0]     eu_act_mask_o;
  logic [2:0]     eu_warp_id_o;
  logic [7:0]     eu_dst_o;
  logic [255:0]   eu_operands_o;

  operand_collector dut (
    .clk_i            (clk_i),
    .rst_ni           (rst_ni),
    .disp_valid_i     (disp_valid_i),
    .opc_ready_o      (opc_ready_o),
    .disp_pc_i        (disp_pc_i),
    .disp_act_mask_i  (disp_act_mask_i),
    .disp_warp_id_i   (disp_warp_id_i),
    .disp_dst_i       (disp_dst_i),
    .disp_src_i       (disp_src_i),
    .rf_req_valid_o   (rf_req_valid_o),
    .rf_req_ready_i   (rf_req_ready_i),
    .rf_req_warp_id_o (rf_req_warp_id_o),
    .rf_req_reg_idx_o (rf_req_reg_idx_o),
    .rf_rsp_valid_i   (rf_rsp_valid_i),
    .rf_rsp_data_i    (rf_rsp_data_i),
    .eu_valid_o       (eu_valid_o),
    .eu_ready_i       (eu_ready_i),
    .eu_pc_o          (eu_pc_o),
    .eu_act_mask_o    (eu_act_mask_o),
    .eu_warp_id_o     (eu_warp_id_o),
    .eu_dst_o         (eu_dst_o),
    .eu_operands_o    (eu_operands_o)
  );

  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  typedef struct {
    logic [15:0]  pc;
    logic [3:0]   mask;
    logic [2:0]   wid;
    logic [7:0]   dst;
    logic [255:0] ops;
    int           acc;
    int           lat;
  } eu_exp_t;

  typedef struct {
    logic [2:0] wid;
    logic [7:0] ridx;
  } req_exp_t;

  eu_exp_t  exp_eu[$];
  req_exp_t exp_req[$];

  int n_chk = 0;
  int n_pass = 0;
  int req_stall = 0;
  int rsp_delay = 0;
  int eu_stall = 0;
  int n_req = 0;
  int last_hs = 0;
  bit overlap = 1'b0;

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [OpW-1:0] rf_data(input logic [2:0] w, input logic [7:0] r);
    logic [OpW-1:0] d;
    logic [7:0]     hi;
    hi = 8'hA0 ^ r;
    d  = '0;
    for (int l = 0; l < WW; l++) d[l*32 +: 32] = {hi, 5'd0, w, 8'(l), r};
    return d;
  endfunction

  function automatic logic [OpW-1:0] op_exp(input logic [2:0] w, input logic [7:0] r);
`ifdef OPC_ZERO_REG_EN
    if (r == 8'd0) return '0;
`endif
    return rf_data(w, r);
  endfunction

  always @(negedge clk_i) if (rf_req_valid_o && eu_valid_o) overlap = 1'b1;

  // Register-file responder: stall ready, then answer after rsp_delay cycles
  initial begin : rf_model
    req_exp_t   e;
    logic [2:0] w0;
    logic [7:0] r0;
    rf_req_ready_i = 1'b0;
    rf_rsp_valid_i = 1'b0;
    rf_rsp_data_i  = '0;
    @(negedge clk_i);
    forever begin
      if (rf_req_valid_o) begin
        w0 = rf_req_warp_id_o;
        r0 = rf_req_reg_idx_o;
        for (int i = 0; i < req_stall; i++) begin
          @(negedge clk_i);
          chk("req_hold_valid", rf_req_valid_o, 1);
          chk("req_hold_fields", {rf_req_warp_id_o, rf_req_reg_idx_o}, {w0, r0});
          chk("req_stall_opc_ready", opc_ready_o, 0);
        end
        n_req++;
        chk("req_expected", 256'(exp_req.size() != 0), 1);
        if (exp_req.size() != 0) begin
          e = exp_req.pop_front();
          chk("req_fields", {w0, r0}, {e.wid, e.ridx});
        end
        rf_req_ready_i = 1'b1;
        @(negedge clk_i);
        rf_req_ready_i = 1'b0;
        repeat (rsp_delay) @(negedge clk_i);
        rf_rsp_valid_i = 1'b1;
        rf_rsp_data_i  = rf_data(w0, r0);
        @(negedge clk_i);
        rf_rsp_valid_i = 1'b0;
        rf_rsp_data_i  = '0;
      end else begin
        @(negedge clk_i);
      end
    end
  end

  // Execution-unit sink: hold ready low eu_stall cycles, then compare and accept
  initial begin : eu_model
    eu_exp_t      e;
    logic [15:0]  p0;
    logic [255:0] o0;
    int           first;
    eu_ready_i = 1'b0;
    @(negedge clk_i);
    forever begin
      if (eu_valid_o) begin
        p0    = eu_pc_o;
        o0    = eu_operands_o;
        first = cyc;
        for (int i = 0; i < eu_stall; i++) begin
          @(negedge clk_i);
          chk("eu_hold_valid", eu_valid_o, 1);
          chk("eu_hold_pc", eu_pc_o, p0);
          chk("eu_hold_ops", eu_operands_o, o0);
          chk("eu_stall_opc_ready", opc_ready_o, 0);
        end
        chk("eu_expected", 256'(exp_eu.size() != 0), 1);
        if (exp_eu.size() != 0) begin
          e = exp_eu.pop_front();
          if (e.lat >= 0) chk("eu_latency", first - e.acc, e.lat);
          chk("eu_pc", eu_pc_o, e.pc);
          chk("eu_mask", eu_act_mask_o, e.mask);
          chk("eu_wid", eu_warp_id_o, e.wid);
          chk("eu_dst", eu_dst_o, e.dst);
          chk("eu_ops", eu_operands_o, e.ops);
        end
        eu_ready_i = 1'b1;
        last_hs    = cyc;
        @(negedge clk_i);
        eu_ready_i = 1'b0;
      end else begin
        @(negedge clk_i);
      end
    end
  end

  task automatic send(input logic [15:0] pc, input logic [3:0] m, input logic [2:0] w,
                      input logic [7:0] d, input logic [7:0] s0, input logic [7:0] s1,
                      input int lat, output int acc);
    eu_exp_t  e;
    req_exp_t r;
    int       n;
    n = 0;
    disp_valid_i    = 1'b1;
    disp_pc_i       = pc;
    disp_act_mask_i = m;
    disp_warp_id_i  = w;
    disp_dst_i      = d;
    disp_src_i      = {s1, s0};
    while (!opc_ready_o && n < 300) begin
      @(negedge clk_i);
      n++;
    end
    chk("accept_in_time", opc_ready_o, 1);
    acc = cyc;
    if (opc_ready_o) begin
      e = '{pc: pc, mask: m, wid: w, dst: d, ops: {op_exp(w, s1), op_exp(w, s0)}, acc: cyc, lat: lat};
      exp_eu.push_back(e);
`ifdef OPC_ZERO_REG_EN
      if (s0 != 8'd0) begin r = '{wid: w, ridx: s0}; exp_req.push_back(r); end
      if (s1 != 8'd0) begin r = '{wid: w, ridx: s1}; exp_req.push_back(r); end
`else
      r = '{wid: w, ridx: s0}; exp_req.push_back(r);
      r = '{wid: w, ridx: s1}; exp_req.push_back(r);
`endif
    end
    @(negedge clk_i);
    disp_valid_i = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_eu.size() != 0 && n < 500) begin
      @(negedge clk_i);
      n++;
    end
    chk("drain_eu_queue", exp_eu.size(), 0);
    @(negedge clk_i);
  endtask

  initial begin : timeout
    #200000;
    $display("FAIL global_timeout: got no finish within 20000 cycles, required finish");
    $fatal(1, "bench timeout");
  end

  initial begin : main
    int  a1, a2, n0;
    bit  eu_seen;
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b1;
    @(negedge clk_i);
    chk("rst_opc_ready", opc_ready_o, 1);
    chk("rst_req_valid", rf_req_valid_o, 0);
    chk("rst_eu_valid", eu_valid_o, 0);
    chk("rst_ops", eu_operands_o, 0);
    chk("rst_pc", eu_pc_o, 0);

    send(16'h0010, 4'hF, 3'd3, 8'h20, 8'd5, 8'd7, 5, a1);
    send(16'h1234, 4'b0101, 3'd6, 8'h09, 8'hFE, 8'h01, 5, a1);
    drain();

    req_stall = 3;
    rsp_delay = 4;
    eu_stall  = 5;
    send(16'hBEEF, 4'b1000, 3'd1, 8'h33, 8'h44, 8'h55, -1, a1);
    drain();
    req_stall = 0;
    rsp_delay = 0;
    eu_stall  = 0;

    send(16'h0100, 4'hF, 3'd1, 8'h01, 8'h11, 8'h12, 5, a1);
    send(16'h0200, 4'h3, 3'd5, 8'h02, 8'h21, 8'h22, 5, a2);
    chk("b2b_accept_cycle", a2, last_hs + 1);
    chk("b2b_interval", a2 - a1, 6);
    drain();

    rsp_delay = 10;
    eu_seen   = 1'b0;
    send(16'h0BAD, 4'hF, 3'd2, 8'h77, 8'h03, 8'h04, -1, a1);
    repeat (2) begin
      @(negedge clk_i);
      eu_seen |= eu_valid_o;
    end
    rst_ni = 1'b0;
    repeat (15) begin
      @(negedge clk_i);
      eu_seen |= eu_valid_o;
    end
    rst_ni = 1'b1;
    exp_eu.delete();
    exp_req.delete();
    rsp_delay = 0;
    chk("midrst_opc_ready", opc_ready_o, 1);
    chk("midrst_ops", eu_operands_o, 0);
    repeat (3) begin
      @(negedge clk_i);
      eu_seen |= eu_valid_o;
    end
    chk("midrst_eu_never", eu_seen, 0);
    send(16'h0C0D, 4'h6, 3'd7, 8'h10, 8'h2A, 8'h3B, 5, a1);
    drain();

    n0 = n_req;
    send(16'h0ABC, 4'hF, 3'd4, 8'h05, 8'h00, 8'h00, ZeroLat, a1);
    drain();
    chk("zero_req_count", n_req - n0, ZeroReqs);

    chk("req_queue_empty", exp_req.size(), 0);
    chk("req_eu_exclusive", overlap, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
